// File: rtl/vga_draw_pkg.sv
// Shared timing constants, tile-layout constants, colour codes and the
// snake body-column helper for the VGA snake renderer.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int TILE_SHIFT = 4;
    localparam int SNAKE_ROW  = 15;
    localparam int APPLE_COL  = 30;
    localparam int APPLE_ROW  = 8;
    localparam int HEAD_START = 10;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t C_BLACK  = 3'b000;
    localparam rgb_t C_BLUE   = 3'b001;
    localparam rgb_t C_GREEN  = 3'b010;
    localparam rgb_t C_YELLOW = 3'b110;
    localparam rgb_t C_RED    = 3'b100;

    // Column of the k-th body cell behind the head; wraps within 1..col_max.
    function automatic logic [5:0] body_col(input logic [5:0] head,
                                            input logic [3:0] k,
                                            input logic [5:0] col_max);
        logic [6:0] c;
        c = {1'b0, head} - {3'b000, k};
        if (c[6] || (c == 7'd0))
            c = c + {1'b0, col_max};
        return c[5:0];
    endfunction

endpackage

// File: rtl/vga_draw_if.sv
// Bundle of the five VGA connector pins (colour bits and active-low syncs).
interface vga_draw_if;
    logic red;
    logic grn;
    logic blu;
    logic h_sync;
    logic v_sync;

    modport master (output red, grn, blu, h_sync, v_sync);
    modport slave  (input  red, grn, blu, h_sync, v_sync);
endinterface

// File: rtl/vga_draw_timing.sv
// Horizontal/vertical raster counters with combinational sync, visible and
// frame-end decode.  Sync outputs are active low.
module vga_timing #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       visible,
    output logic       h_sync,
    output logic       v_sync,
    output logic       frame_end
);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign visible   = (h < H_VIS_L) && (v < V_VIS_L);
    assign h_sync    = !((h >= HS_START) && (h < HS_END));
    assign v_sync    = !((v >= VS_START) && (v < VS_END));
    assign frame_end = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_draw.sv
// VGA snake demo: raster timing, 16x16 tile decode, snake motion state and
// registered pin outputs (all five pins share one clock of latency).
module vga_draw #(
    parameter int MOVE_FRAMES = 8,
    parameter int SNAKE_LEN   = 4,
    parameter int H_VIS       = vga_pkg::H_VIS,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_VIS       = vga_pkg::V_VIS,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int SNAKE_ROW   = vga_pkg::SNAKE_ROW,
    parameter int APPLE_COL   = vga_pkg::APPLE_COL,
    parameter int APPLE_ROW   = vga_pkg::APPLE_ROW,
    parameter int HEAD_START  = vga_pkg::HEAD_START
) (
    input  logic clk,
    input  logic reset,
    output logic red_o,
    output logic grn_o,
    output logic blu_o,
    output logic h_sync_o,
    output logic v_sync_o
);
    import vga_pkg::*;

    localparam int COLS = H_VIS >> TILE_SHIFT;
    localparam int ROWS = V_VIS >> TILE_SHIFT;
    localparam int FW   = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    localparam logic [5:0]    COL_LAST = 6'(COLS - 1);
    localparam logic [5:0]    COL_MAX  = 6'(COLS - 2);
    localparam logic [5:0]    HEAD0    = 6'(HEAD_START);
    localparam logic [5:0]    A_COL    = 6'(APPLE_COL);
    localparam logic [4:0]    ROW_LAST = 5'(ROWS - 1);
    localparam logic [4:0]    S_ROW    = 5'(SNAKE_ROW);
    localparam logic [4:0]    A_ROW    = 5'(APPLE_ROW);
    localparam logic [FW-1:0] FC_LAST  = FW'(MOVE_FRAMES - 1);

    logic [9:0]    t_h;
    logic [9:0]    t_v;
    logic          t_visible;
    logic          t_hs;
    logic          t_vs;
    logic          frame_end;
    logic [5:0]    col;
    logic [4:0]    row;
    logic [5:0]    head_col;
    logic [FW-1:0] frame_cnt;
    logic          body_hit;
    rgb_t          rgb;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .h         (t_h),
        .v         (t_v),
        .visible   (t_visible),
        .h_sync    (t_hs),
        .v_sync    (t_vs),
        .frame_end (frame_end)
    );

    assign col = 6'(t_h >> TILE_SHIFT);
    assign row = 5'(t_v >> TILE_SHIFT);

    always_comb begin
        body_hit = 1'b0;
        rgb      = C_BLACK;
        for (int k = 1; k < SNAKE_LEN; k++) begin
            if (col == body_col(head_col, 4'(k), COL_MAX))
                body_hit = 1'b1;
        end
        // First match wins: border, head, body, apple, background.
        if (!t_visible)
            rgb = C_BLACK;
        else if ((col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST))
            rgb = C_BLUE;
        else if ((row == S_ROW) && (col == head_col))
            rgb = C_YELLOW;
        else if ((row == S_ROW) && body_hit)
            rgb = C_GREEN;
        else if ((col == A_COL) && (row == A_ROW))
            rgb = C_RED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_o     <= 1'b0;
            grn_o     <= 1'b0;
            blu_o     <= 1'b0;
            h_sync_o  <= 1'b1;
            v_sync_o  <= 1'b1;
            frame_cnt <= '0;
            head_col  <= HEAD0;
        end else begin
            red_o    <= rgb.r;
            grn_o    <= rgb.g;
            blu_o    <= rgb.b;
            h_sync_o <= t_hs;
            v_sync_o <= t_vs;
            // Snake state only moves at frame end so a frame never tears.
            if (frame_end) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    head_col  <= (head_col == COL_MAX) ? 6'd1 : head_col + 6'd1;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_draw.sv
// Bench for vga_draw: a full-size instance and a shrunken-raster instance
// driven by one random reset schedule, checked against an arithmetic model.
module tb_vga_draw;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        int move, slen, srow, acol, arow, head0;
    } cfg_t;

    localparam int B_HV = 160, B_HF = 8, B_HS = 16, B_HB = 8;
    localparam int B_VV = 64,  B_VF = 2, B_VS = 2,  B_VB = 4;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 8, 4, 15, 30, 8, 10};
    cfg_t cfg_b = '{B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1, 4, 1, 5, 1, 7};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   run = 0;

    logic [4:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];
    int         run_q[$];

    always #20 clk = ~clk;

    vga_draw_if vif_a();
    vga_draw_if vif_b();

    vga_draw dut_a (
        .clk      (clk),
        .reset    (reset),
        .red_o    (vif_a.red),
        .grn_o    (vif_a.grn),
        .blu_o    (vif_a.blu),
        .h_sync_o (vif_a.h_sync),
        .v_sync_o (vif_a.v_sync)
    );

    vga_draw #(
        .MOVE_FRAMES (1), .SNAKE_LEN (4),
        .H_VIS (B_HV), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_VIS (B_VV), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .SNAKE_ROW (1), .APPLE_COL (5), .APPLE_ROW (1), .HEAD_START (7)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .red_o    (vif_b.red),
        .grn_o    (vif_b.grn),
        .blu_o    (vif_b.blu),
        .h_sync_o (vif_b.h_sync),
        .v_sync_o (vif_b.v_sync)
    );

    // Expected {r,g,b,hsync,vsync} after the run-th clock since reset release.
    function automatic logic [4:0] model(input cfg_t c, input int n);
        int ht, vt, p, frame, pos, h, v, col, row, cols, rows, cmax, head, d;
        logic hs_n, vs_n;
        logic [2:0] rgb;
        if (n == 0) return 5'b000_11;
        ht    = c.hv + c.hf + c.hs + c.hb;
        vt    = c.vv + c.vf + c.vs + c.vb;
        p     = n - 1;
        frame = p / (ht * vt);
        pos   = p % (ht * vt);
        h     = pos % ht;
        v     = pos / ht;
        hs_n  = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
        vs_n  = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
        rgb   = 3'b000;
        if (h < c.hv && v < c.vv) begin
            col  = h / 16;
            row  = v / 16;
            cols = c.hv / 16;
            rows = c.vv / 16;
            cmax = cols - 2;
            head = (c.head0 - 1 + frame / c.move) % cmax + 1;
            d    = (head - col + cmax) % cmax;
            if (col == 0 || col == cols - 1 || row == 0 || row == rows - 1) rgb = 3'b001;
            else if (row == c.srow && col == head)                       rgb = 3'b110;
            else if (row == c.srow && d >= 1 && d < c.slen)              rgb = 3'b010;
            else if (col == c.acol && row == c.arow)                     rgb = 3'b100;
        end
        return {rgb, hs_n, vs_n};
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_pix(input string name, input int n, input logic [4:0] got,
                             input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s run=%0d got=%b exp=%b (rgb,hs,vs)", name, n, got, exp);
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        reset = r;
        @(posedge clk);
        #1;
        if (r) run = 0;
        else   run++;
        run_q.push_back(run);
        exp_a_q.push_back(model(cfg_a, run));
        exp_b_q.push_back(model(cfg_b, run));
    endtask

    task automatic run_for(input int n);
        for (int i = 0; i < n && bad < 40; i++) step(1'b0);
    endtask

    // Monitor: pops one expectation per clock and checks sync pulse shapes.
    int   m_run;
    logic [4:0] ea, eb;
    int   hs_cnt = 0, hs_fall = 0, vs_cnt = 0, vs_fall = 0;
    bit   hs_seen = 0, vs_seen = 0;

    always @(negedge clk) begin
        if (run_q.size() > 0) begin
            m_run = run_q.pop_front();
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            check_pix("pix_a", m_run,
                      {vif_a.red, vif_a.grn, vif_a.blu, vif_a.h_sync, vif_a.v_sync}, ea);
            check_pix("pix_b", m_run,
                      {vif_b.red, vif_b.grn, vif_b.blu, vif_b.h_sync, vif_b.v_sync}, eb);
            if (m_run == 0) begin
                hs_cnt = 0; hs_seen = 0; vs_cnt = 0; vs_seen = 0;
            end else begin
                if (!vif_a.h_sync) begin
                    if (hs_cnt == 0) begin
                        if (!hs_seen) check_int("hsync_first_fall", m_run, 657);
                        else          check_int("hsync_period", m_run - hs_fall, 800);
                        hs_seen = 1;
                        hs_fall = m_run;
                    end
                    hs_cnt++;
                end else if (hs_cnt != 0) begin
                    check_int("hsync_width", hs_cnt, 96);
                    hs_cnt = 0;
                end
                if (!vif_b.v_sync) begin
                    if (vs_cnt == 0) begin
                        if (!vs_seen) check_int("vsync_first_fall_b", m_run, (B_VV + B_VF) * B_HT + 1);
                        else          check_int("vsync_period_b", m_run - vs_fall, B_HT * B_VT);
                        vs_seen = 1;
                        vs_fall = m_run;
                    end
                    vs_cnt++;
                end else if (vs_cnt != 0) begin
                    check_int("vsync_width_b", vs_cnt, B_VS * B_HT);
                    vs_cnt = 0;
                end
            end
        end
    end

    initial begin
        step(1'b1);
        run_for($urandom_range(2000, 5000));
        repeat ($urandom_range(1, 3)) step(1'b1);
        run_for($urandom_range(1500, 4000));
        step(1'b1);
        run_for(70000);
        @(negedge clk);
        #1;
        check_int("queue_drained", run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
